// File: rtl/program_loader.sv
// program_loader: boot-time byte-stream loader that fills instruction memory and releases the CPU
module program_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned TIMEOUT   = 1000,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        ins_we_o,
    output logic [31:0] ins_addr_o,
    output logic [31:0] ins_data_o,
    output logic [31:0] pc_value_o,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        error_o
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q;
    logic [39:0] shift_q;
    logic [7:0]  xor_q;
    logic [31:0] timer_q;
    logic [15:0] idx_q, n_q;
    logic [31:0] pc_q, addr_q, data_q;
    logic        accept, in_frame, timed_out;
    logic [15:0] n_new;
    assign accept    = byte_valid_i && byte_ready_o;
    assign in_frame  = state_q == S_HDR || state_q == S_DATA || state_q == S_CHECK;
    assign timed_out = in_frame && !accept && timer_q == TIMEOUT - 1;
    assign n_new     = {shift_q[7:0], byte_data_i};
    // state and datapath registers; the header shift register keeps PC in [39:8] until N completes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            xor_q   <= '0;
            timer_q <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            pc_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= accept ? 32'd0 : in_frame ? timer_q + 32'd1 : timer_q;
            if (accept) begin
                shift_q <= {shift_q[31:0], byte_data_i};
                xor_q   <= xor_q ^ byte_data_i;
                cnt_q   <= ((state_q == S_HDR && cnt_q == 3'd5) || (state_q == S_DATA && cnt_q == 3'd3)) ? 3'd0 : cnt_q + 3'd1;
            end
            if (state_q == S_HDR && state_d == S_DATA) begin
                pc_q <= shift_q[39:8];
                n_q  <= n_new;
            end
            if (state_q == S_DATA && state_d == S_WRITE) begin
                addr_q <= BASE_ADDR + {14'b0, idx_q, 2'b00};
                data_q <= {shift_q[23:0], byte_data_i};
            end
            if (state_q == S_WRITE)
                idx_q <= idx_q + 16'd1;
        end
    end
    // next-state decode; an accepted byte always beats the idle timeout
    always_comb begin
        state_d = state_q;
        if (timed_out)
            state_d = S_ERROR;
        else
            case (state_q)
                S_IDLE:  state_d = accept ? S_HDR : S_IDLE;
                S_HDR:   if (accept && cnt_q == 3'd5)
                             state_d = (n_new == 16'd0 || 32'(n_new) > MAX_WORDS) ? S_ERROR : S_DATA;
                S_DATA:  state_d = (accept && cnt_q == 3'd3) ? S_WRITE : S_DATA;
                S_WRITE: state_d = idx_q == n_q - 16'd1 ? S_CHECK : S_DATA;
                S_CHECK: if (accept) state_d = byte_data_i == xor_q ? S_DONE : S_ERROR;
                default: state_d = state_q;
            endcase
    end
    // outputs decoded from the registered state
    always_comb begin
        byte_ready_o = in_frame || state_q == S_IDLE;
        ins_we_o     = state_q == S_WRITE;
        ins_addr_o   = addr_q;
        ins_data_o   = data_q;
        pc_value_o   = pc_q;
        cpu_rst_o    = state_q != S_DONE;
        done_o       = state_q == S_DONE;
        error_o      = state_q == S_ERROR;
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed-vector bench for program_loader
module tb_program_loader;
    localparam int unsigned TO = 20;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'h00;
    logic        byte_ready_o, ins_we_o, cpu_rst_o, done_o, error_o;
    logic [31:0] ins_addr_o, ins_data_o, pc_value_o;
    int          n_vec = 0;
    int          n_err = 0;
    int          ready_in_we = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  stream[$];

    program_loader #(.TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .byte_valid_i(byte_valid_i), .byte_data_i(byte_data_i),
        .byte_ready_o(byte_ready_o), .ins_we_o(ins_we_o), .ins_addr_o(ins_addr_o),
        .ins_data_o(ins_data_o), .pc_value_o(pc_value_o), .cpu_rst_o(cpu_rst_o),
        .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (ins_we_o) begin
            wr_addr.push_back(ins_addr_o);
            wr_data.push_back(ins_data_o);
            if (byte_ready_o) ready_in_we++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int k;
        @(negedge clk_i);
        byte_valid_i = 1'b1;
        byte_data_i = b;
        k = 0;
        while (!byte_ready_o && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        if (k == 50) check("ready_wait", {31'b0, byte_ready_o}, 32'd1);
        @(posedge clk_i);
        if (gap) begin
            @(negedge clk_i);
            byte_valid_i = 1'b0;
        end
    endtask

    task automatic send_all(input bit gap);
        foreach (stream[i]) send_byte(stream[i], gap);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_we", {31'b0, ins_we_o}, 32'd0);
        check("rst_addr", ins_addr_o, 32'd0);
        check("rst_data", ins_data_o, 32'd0);
        check("rst_pc", pc_value_o, 32'd0);
        check("rst_flags", {28'b0, cpu_rst_o, done_o, error_o, byte_ready_o}, 32'b1001);

        // 1: two-word load with gaps between bytes
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h08,
                   8'h20, 8'h02, 8'h00, 8'h02, 8'h0B};
        send_all(1'b1);
        check("t1_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("t1_addr0", wr_addr[0], 32'h0);
            check("t1_data0", wr_data[0], 32'h20010008);
            check("t1_addr1", wr_addr[1], 32'h4);
            check("t1_data1", wr_data[1], 32'h20020002);
        end
        check("t1_pc", pc_value_o, 32'h0);
        check("t1_flags", {29'b0, cpu_rst_o, done_o, error_o}, 32'b010);

        // 2: bad checksum
        do_reset();
        stream[14] = 8'h0C;
        send_all(1'b0);
        check("t2_nwr", wr_addr.size(), 32'd2);
        check("t2_flags", {29'b0, cpu_rst_o, done_o, error_o}, 32'b101);

        // 3: illegal word counts, and the largest legal count
        do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_all(1'b0);
        check("t3_zero_err", {31'b0, error_o}, 32'd1);
        check("t3_zero_ready", {31'b0, byte_ready_o}, 32'd0);
        do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
        send_all(1'b0);
        check("t3_big_err", {31'b0, error_o}, 32'd1);
        repeat (3) @(negedge clk_i);
        check("t3_nwr", wr_addr.size(), 32'd0);
        do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        send_all(1'b0);
        check("t3_max_ok", {30'b0, error_o, byte_ready_o}, 32'b01);

        // 4: timeout after 3 data bytes
        do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC};
        foreach (stream[i]) send_byte(stream[i], 1'b0);
        @(negedge clk_i);
        byte_valid_i = 1'b0;
        repeat (TO - 1) @(negedge clk_i);
        check("t4_early", {31'b0, error_o}, 32'd0);
        @(negedge clk_i);
        check("t4_err", {30'b0, error_o, cpu_rst_o}, 32'b11);
        check("t4_nwr", wr_addr.size(), 32'd0);

        // 5: continuous valid, nonzero PC, single word
        do_reset();
        ready_in_we = 0;
        stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h2B};
        send_all(1'b0);
        check("t5_pc", pc_value_o, 32'h12345678);
        check("t5_nwr", wr_addr.size(), 32'd1);
        if (wr_addr.size() == 1) begin
            check("t5_addr", wr_addr[0], 32'h0);
            check("t5_data", wr_data[0], 32'hDEADBEEF);
        end
        check("t5_flags", {29'b0, cpu_rst_o, done_o, error_o}, 32'b010);
        do_reset();
        stream = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h08,
                   8'h20, 8'h02, 8'h00, 8'h02, 8'h0B};
        send_all(1'b0);
        check("t5b_nwr", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) check("t5b_data1", wr_data[1], 32'h20020002);
        check("t5b_done", {31'b0, done_o}, 32'd1);
        check("t5_ready_in_we", ready_in_we, 32'd0);

        // 6: reset during DATA, then a fresh load
        do_reset();
        for (int i = 0; i < 9; i++) send_byte(stream[i], 1'b0);
        do_reset();
        check("t6_flags", {28'b0, cpu_rst_o, done_o, error_o, byte_ready_o}, 32'b1001);
        repeat (4) @(negedge clk_i);
        check("t6_nwr", wr_addr.size(), 32'd0);
        send_all(1'b1);
        check("t6_nwr2", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) check("t6_data0", wr_data[0], 32'h20010008);
        check("t6_flags2", {29'b0, cpu_rst_o, done_o, error_o}, 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
